// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-event allocator in front of the FM voice bank.
// Accepts note-on/note-off events, scans the voices one per cycle to choose a
// target (retrigger, free, oldest releasing, steal oldest active), then issues
// one-cycle register writes (optional kill, then KeyOn write) to the voice bank.
// Per-voice age counters advance on sample ticks so release tails finish
// before a voice is reused.
module voice_allocator #(
    parameter int unsigned NUM_VOICES    = 8,
    parameter int unsigned VIDX_WIDTH    = $clog2(NUM_VOICES),
    parameter int unsigned AGE_WIDTH     = 8,
    parameter int unsigned RELEASE_TICKS = 32
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic                            i_SampleTick,
    input  logic                            i_EventValid,
    output logic                            o_EventReady,
    input  logic                            i_EventNoteOn,
    input  logic [6:0]                      i_EventNote,
    input  logic [6:0]                      i_EventVelocity,
    output logic                            o_WriteEnable,
    output logic [VIDX_WIDTH-1:0]           o_WriteVoice,
    output logic                            o_WriteKeyOn,
    output logic [6:0]                      o_WriteNote,
    output logic [6:0]                      o_WriteVelocity,
    output logic [NUM_VOICES-1:0]           o_VoiceKeyOn,
    output logic [$clog2(NUM_VOICES+1)-1:0] o_ActiveCount
);

    localparam int unsigned CntWidth = $clog2(NUM_VOICES + 1);

    localparam logic [AGE_WIDTH-1:0]  AgeMax   = {AGE_WIDTH{1'b1}};
    localparam logic [AGE_WIDTH-1:0]  RelTicks = AGE_WIDTH'(RELEASE_TICKS);
    localparam logic [VIDX_WIDTH-1:0] LastIdx  = VIDX_WIDTH'(NUM_VOICES - 1);

    // Candidate ranks for note-on; lower value wins.
    localparam logic [1:0] RankRetrig = 2'd0;
    localparam logic [1:0] RankFree   = 2'd1;
    localparam logic [1:0] RankRel    = 2'd2;
    localparam logic [1:0] RankSteal  = 2'd3;

    typedef enum logic [1:0] {
        VsFree,
        VsActive,
        VsRel
    } vstate_e;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StKill,
        StWrite
    } fsm_e;

    // Sequencer state
    fsm_e                  fsm_q;
    logic                  ready_q;
    logic                  ev_on_q;
    logic [6:0]            ev_note_q;
    logic [6:0]            ev_vel_q;
    logic [VIDX_WIDTH-1:0] scan_idx_q;
    logic                  found_q;
    logic [VIDX_WIDTH-1:0] best_idx_q;
    logic [1:0]            best_rank_q;
    logic [AGE_WIDTH-1:0]  best_age_q;

    // Registered write port
    logic                  we_q;
    logic [VIDX_WIDTH-1:0] wvoice_q;
    logic                  wkey_q;
    logic [6:0]            wnote_q;
    logic [6:0]            wvel_q;

    // Per-voice state
    vstate_e               vst_q   [NUM_VOICES];
    logic [6:0]            vnote_q [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  vage_q  [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  age_inc [NUM_VOICES];
    logic                  pend_q;
    logic                  tick_now;

    // Status outputs
    logic [NUM_VOICES-1:0] keyon_d;
    logic [NUM_VOICES-1:0] keyon_q;
    logic [CntWidth-1:0]   count_d;
    logic [CntWidth-1:0]   count_q;

    // Scan step signals
    vstate_e               cur_st;
    logic [6:0]            cur_note;
    logic [AGE_WIDTH-1:0]  cur_age;
    logic                  cur_match;
    logic [1:0]            cur_rank;
    logic                  take;
    logic                  nxt_found;
    logic [VIDX_WIDTH-1:0] nxt_idx;
    logic                  kill_needed;

    // Evaluate the voice under the scan pointer against the best candidate so far.
    always_comb begin
        cur_st    = vst_q[scan_idx_q];
        cur_note  = vnote_q[scan_idx_q];
        cur_age   = vage_q[scan_idx_q];
        cur_match = (cur_st != VsFree) && (cur_note == ev_note_q);
        if (cur_match) begin
            cur_rank = RankRetrig;
        end else if (cur_st == VsFree) begin
            cur_rank = RankFree;
        end else if (cur_st == VsRel) begin
            cur_rank = RankRel;
        end else begin
            cur_rank = RankSteal;
        end

        if (ev_on_q) begin
            // Strict comparisons keep the lowest index on ties.
            take = !found_q
                || (cur_rank < best_rank_q)
                || ((cur_rank == best_rank_q) && (cur_rank >= RankRel)
                    && (cur_age > best_age_q));
        end else begin
            take = !found_q && (cur_st == VsActive) && (cur_note == ev_note_q);
        end

        nxt_found   = found_q | take;
        nxt_idx     = take ? scan_idx_q : best_idx_q;
        kill_needed = ev_on_q && (vst_q[nxt_idx] == VsActive);
    end

    // Event sequencer: accept, scan, optional kill, write; drives the write port.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            fsm_q       <= StIdle;
            ready_q     <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            scan_idx_q  <= '0;
            found_q     <= 1'b0;
            best_idx_q  <= '0;
            best_rank_q <= '0;
            best_age_q  <= '0;
            we_q        <= 1'b0;
            wvoice_q    <= '0;
            wkey_q      <= 1'b0;
            wnote_q     <= '0;
            wvel_q      <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (fsm_q)
                StIdle: begin
                    if (ready_q && i_EventValid) begin
                        ready_q    <= 1'b0;
                        ev_on_q    <= i_EventNoteOn;
                        ev_note_q  <= i_EventNote;
                        ev_vel_q   <= i_EventVelocity;
                        scan_idx_q <= '0;
                        found_q    <= 1'b0;
                        fsm_q      <= StScan;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StScan: begin
                    if (take) begin
                        found_q     <= 1'b1;
                        best_idx_q  <= scan_idx_q;
                        best_rank_q <= cur_rank;
                        best_age_q  <= cur_age;
                    end
                    scan_idx_q <= scan_idx_q + 1'b1;
                    if (scan_idx_q == LastIdx) begin
                        // Only an unmatched note-off can finish without a target.
                        if (!nxt_found) begin
                            fsm_q <= StIdle;
                        end else if (kill_needed) begin
                            fsm_q <= StKill;
                        end else begin
                            fsm_q <= StWrite;
                        end
                    end
                end
                StKill: begin
                    we_q     <= 1'b1;
                    wvoice_q <= best_idx_q;
                    wkey_q   <= 1'b0;
                    wnote_q  <= vnote_q[best_idx_q];
                    wvel_q   <= '0;
                    fsm_q    <= StWrite;
                end
                StWrite: begin
                    we_q     <= 1'b1;
                    wvoice_q <= best_idx_q;
                    wkey_q   <= ev_on_q;
                    wnote_q  <= ev_note_q;
                    wvel_q   <= ev_on_q ? ev_vel_q : 7'd0;
                    fsm_q    <= StIdle;
                end
                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

    // Saturating increment of each voice age, and the tick that applies this cycle.
    always_comb begin
        tick_now = (fsm_q == StIdle) && (i_SampleTick || pend_q);
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            age_inc[v] = (vage_q[v] == AgeMax) ? vage_q[v] : vage_q[v] + 1'b1;
        end
    end

    // Voice state: aging/release on ticks while idle, target update on the final write.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            pend_q <= 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                vst_q[v]   <= VsFree;
                vnote_q[v] <= '0;
                vage_q[v]  <= '0;
            end
        end else begin
            // Ticks seen while busy collapse into one, applied on return to idle.
            if (fsm_q == StIdle) begin
                pend_q <= 1'b0;
            end else if (i_SampleTick) begin
                pend_q <= 1'b1;
            end

            if (tick_now) begin
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    if (vst_q[v] != VsFree) begin
                        if ((vst_q[v] == VsRel) && (age_inc[v] == RelTicks)) begin
                            vst_q[v]  <= VsFree;
                            vage_q[v] <= '0;
                        end else begin
                            vage_q[v] <= age_inc[v];
                        end
                    end
                end
            end

            // tick_now is never set in StWrite, so these updates cannot collide.
            if (fsm_q == StWrite) begin
                vst_q[best_idx_q]   <= ev_on_q ? VsActive : VsRel;
                vnote_q[best_idx_q] <= ev_note_q;
                vage_q[best_idx_q]  <= '0;
            end
        end
    end

    // Key-on mask and active count derived from the voice state vector.
    always_comb begin
        count_d = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            keyon_d[v] = (vst_q[v] == VsActive);
            count_d    = count_d + CntWidth'(keyon_d[v]);
        end
    end

    // Register the status outputs one cycle behind the state vector.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            keyon_q <= '0;
            count_q <= '0;
        end else begin
            keyon_q <= keyon_d;
            count_q <= count_d;
        end
    end

    assign o_EventReady    = ready_q;
    assign o_WriteEnable   = we_q;
    assign o_WriteVoice    = wvoice_q;
    assign o_WriteKeyOn    = wkey_q;
    assign o_WriteNote     = wnote_q;
    assign o_WriteVelocity = wvel_q;
    assign o_VoiceKeyOn    = keyon_q;
    assign o_ActiveCount   = count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven, directed and randomized checks of voice_allocator.
module tb_voice_allocator;

    localparam int N   = 8;
    localparam int REL = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic       ev_on = 1'b0;
    logic [6:0] ev_note = '0;
    logic [6:0] ev_vel = '0;

    logic       o_EventReady;
    logic       o_WriteEnable;
    logic [2:0] o_WriteVoice;
    logic       o_WriteKeyOn;
    logic [6:0] o_WriteNote;
    logic [6:0] o_WriteVelocity;
    logic [7:0] o_VoiceKeyOn;
    logic [3:0] o_ActiveCount;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES   (N),
        .AGE_WIDTH    (8),
        .RELEASE_TICKS(REL)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_SampleTick   (tick),
        .i_EventValid   (valid),
        .o_EventReady   (o_EventReady),
        .i_EventNoteOn  (ev_on),
        .i_EventNote    (ev_note),
        .i_EventVelocity(ev_vel),
        .o_WriteEnable  (o_WriteEnable),
        .o_WriteVoice   (o_WriteVoice),
        .o_WriteKeyOn   (o_WriteKeyOn),
        .o_WriteNote    (o_WriteNote),
        .o_WriteVelocity(o_WriteVelocity),
        .o_VoiceKeyOn   (o_VoiceKeyOn),
        .o_ActiveCount  (o_ActiveCount)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 0 = free, 1 = active, 2 = releasing
    int m_st   [N];
    int m_note [N];
    int m_age  [N];

    // Expected writes for the current event
    int e_n;
    int e_v  [2];
    int e_k  [2];
    int e_nt [2];
    int e_vl [2];

    // Observed writes for the current event
    int o_n;
    int o_v  [2];
    int o_k  [2];
    int o_nt [2];
    int o_vl [2];
    int o_ed [2];
    int rdy_edge;
    bit acc_tick;
    bit busy_tick;

    task automatic m_reset();
        for (int v = 0; v < N; v++) begin
            m_st[v] = 0;
            m_note[v] = 0;
            m_age[v] = 0;
        end
    endtask

    task automatic m_tick();
        for (int v = 0; v < N; v++) begin
            if (m_st[v] != 0) begin
                m_age[v] = (m_age[v] < 255) ? m_age[v] + 1 : 255;
                if (m_st[v] == 2 && m_age[v] == REL) begin
                    m_st[v] = 0;
                    m_age[v] = 0;
                end
            end
        end
    endtask

    task automatic m_event(input int on_, input int note_, input int vel_);
        int pick;
        pick = -1;
        e_n = 0;
        if (on_ != 0) begin
            for (int v = 0; v < N; v++)
                if (pick < 0 && m_st[v] != 0 && m_note[v] == note_) pick = v;
            for (int v = 0; v < N; v++)
                if (pick < 0 && m_st[v] == 0) pick = v;
            for (int s = 2; s >= 1; s--) begin
                if (pick < 0) begin
                    for (int v = 0; v < N; v++)
                        if (m_st[v] == s && (pick < 0 || m_age[v] > m_age[pick])) pick = v;
                end
            end
            if (m_st[pick] == 1) begin
                e_v[0] = pick; e_k[0] = 0; e_nt[0] = m_note[pick]; e_vl[0] = 0;
                e_n = 1;
            end
            e_v[e_n] = pick; e_k[e_n] = 1; e_nt[e_n] = note_; e_vl[e_n] = vel_;
            e_n++;
            m_st[pick] = 1; m_note[pick] = note_; m_age[pick] = 0;
        end else begin
            for (int v = 0; v < N; v++)
                if (pick < 0 && m_st[v] == 1 && m_note[v] == note_) pick = v;
            if (pick >= 0) begin
                e_v[0] = pick; e_k[0] = 0; e_nt[0] = note_; e_vl[0] = 0;
                e_n = 1;
                m_st[pick] = 2; m_age[pick] = 0;
            end
        end
    endtask

    function automatic int m_keyon();
        int mask = 0;
        for (int v = 0; v < N; v++) if (m_st[v] == 1) mask |= (1 << v);
        return mask;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int v = 0; v < N; v++) if (m_st[v] == 1) c++;
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; tick = 1'b0;
        step();
        step();
        chk("reset ready", int'(o_EventReady), 0);
        chk("reset we", int'(o_WriteEnable), 0);
        chk("reset wfields", int'({o_WriteVoice, o_WriteKeyOn, o_WriteNote, o_WriteVelocity}), 0);
        chk("reset keyon", int'(o_VoiceKeyOn), 0);
        chk("reset count", int'(o_ActiveCount), 0);
        rst = 1'b0;
        #1;
        chk("ready low before first edge", int'(o_EventReady), 0);
        step();
        chk("ready on first edge", int'(o_EventReady), 1);
        m_reset();
    endtask

    // Offer one event and record every write strobe until ready returns.
    task automatic run_event(input bit on_, input int note_, input int vel_, input bit rnd);
        for (int w = 0; w < 40 && !o_EventReady; w++) step();
        if (!o_EventReady) chk("ready before event", 0, 1);
        valid = 1'b1; ev_on = on_; ev_note = 7'(note_); ev_vel = 7'(vel_);
        acc_tick = rnd && ($urandom_range(0, 2) == 0);
        tick = acc_tick;
        step();
        valid = 1'b0;
        busy_tick = 1'b0;
        o_n = 0;
        rdy_edge = -1;
        for (int e = 1; e <= 20 && rdy_edge < 0; e++) begin
            tick = rnd && ($urandom_range(0, 3) == 0);
            if (tick) busy_tick = 1'b1;
            step();
            if (o_WriteEnable) begin
                if (o_n < 2) begin
                    o_v[o_n] = int'(o_WriteVoice); o_k[o_n] = int'(o_WriteKeyOn);
                    o_nt[o_n] = int'(o_WriteNote); o_vl[o_n] = int'(o_WriteVelocity);
                    o_ed[o_n] = e;
                end
                o_n++;
            end
            if (o_EventReady) rdy_edge = e;
        end
        tick = 1'b0;
        if (rdy_edge < 0) chk("ready timeout", 0, 1);
    endtask

    task automatic check_event(input string tag, input int keyon, input int cnt);
        chk({tag, " writes"}, o_n, e_n);
        for (int i = 0; i < 2; i++) begin
            if (i < e_n && i < o_n) begin
                chk({tag, " voice"}, o_v[i], e_v[i]);
                chk({tag, " keyon"}, o_k[i], e_k[i]);
                chk({tag, " note"}, o_nt[i], e_nt[i]);
                chk({tag, " vel"}, o_vl[i], e_vl[i]);
                chk({tag, " strobe edge"}, o_ed[i], N + 1 + i);
            end
        end
        chk({tag, " ready edge"}, rdy_edge, N + 1 + e_n);
        chk({tag, " keyon mask"}, int'(o_VoiceKeyOn), keyon);
        chk({tag, " active count"}, int'(o_ActiveCount), cnt);
    endtask

    typedef struct {
        bit on;
        int note;
        int vel;
        int wr;
        int kill;
        int voice;
        int old_note;
        int keyon;
        int cnt;
    } vec_t;

    vec_t vt [10];

    initial begin
        // Table of events applied back to back from reset, without ticks.
        vt[0] = '{1, 60, 100, 1, 0, 0, 0,  8'h01, 1};
        vt[1] = '{1, 61, 90,  1, 0, 1, 0,  8'h03, 2};
        vt[2] = '{0, 60, 33,  1, 0, 0, 0,  8'h02, 1};
        vt[3] = '{1, 60, 50,  1, 0, 0, 0,  8'h03, 2};
        vt[4] = '{1, 61, 70,  1, 1, 1, 61, 8'h03, 2};
        vt[5] = '{0, 72, 5,   0, 0, 0, 0,  8'h03, 2};
        vt[6] = '{0, 61, 9,   1, 0, 1, 0,  8'h01, 1};
        vt[7] = '{1, 62, 10,  1, 0, 2, 0,  8'h05, 2};
        vt[8] = '{0, 62, 0,   1, 0, 2, 0,  8'h01, 1};
        vt[9] = '{1, 63, 20,  1, 0, 3, 0,  8'h09, 2};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_event(vt[i].on, vt[i].note, vt[i].vel, 1'b0);
            e_n = 0;
            if (vt[i].wr != 0) begin
                if (vt[i].kill != 0) begin
                    e_v[0] = vt[i].voice; e_k[0] = 0; e_nt[0] = vt[i].old_note; e_vl[0] = 0;
                    e_n = 1;
                end
                e_v[e_n] = vt[i].voice; e_k[e_n] = int'(vt[i].on);
                e_nt[e_n] = vt[i].note; e_vl[e_n] = vt[i].on ? vt[i].vel : 0;
                e_n++;
            end
            check_event($sformatf("vec%0d", i), vt[i].keyon, vt[i].cnt);
        end

        // Steal the oldest active voice once all are busy.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_event(1'b1, 60 + i, 100, 1'b0);
            for (int t = 0; t < 3; t++) begin
                tick = 1'b1; step(); tick = 1'b0;
            end
        end
        run_event(1'b1, 70, 80, 1'b0);
        chk("steal writes", o_n, 2);
        chk("steal kill voice", o_v[0], 0);
        chk("steal kill keyon", o_k[0], 0);
        chk("steal kill note", o_nt[0], 60);
        chk("steal kill edge", o_ed[0], 9);
        chk("steal write voice", o_v[1], 0);
        chk("steal write note", o_nt[1], 70);
        chk("steal write edge", o_ed[1], 10);
        chk("steal keyon mask", int'(o_VoiceKeyOn), 8'hff);

        // Release tail: voice 0 frees on the 32nd tick.
        do_reset();
        run_event(1'b1, 60, 100, 1'b0);
        run_event(1'b0, 60, 0, 1'b0);
        chk("release keyon", int'(o_VoiceKeyOn), 0);
        for (int t = 0; t < 31; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        run_event(1'b1, 65, 40, 1'b0);
        chk("rel 31 ticks voice", o_v[0], 1);
        tick = 1'b1; step(); tick = 1'b0;
        run_event(1'b1, 66, 41, 1'b0);
        chk("rel 32 ticks voice", o_v[0], 0);
        chk("rel 32 keyon", int'(o_VoiceKeyOn), 8'h03);

        // Unmatched note-off.
        do_reset();
        run_event(1'b0, 72, 10, 1'b0);
        chk("nomatch writes", o_n, 0);
        chk("nomatch ready edge", rdy_edge, 9);

        // Retrigger of a held note.
        do_reset();
        run_event(1'b1, 60, 100, 1'b0);
        run_event(1'b1, 60, 90, 1'b0);
        chk("retrig writes", o_n, 2);
        chk("retrig kill voice", o_v[0], 0);
        chk("retrig kill keyon", o_k[0], 0);
        chk("retrig write voice", o_v[1], 0);
        chk("retrig write vel", o_vl[1], 90);
        chk("retrig keyon", int'(o_VoiceKeyOn), 8'h01);
        chk("retrig count", int'(o_ActiveCount), 1);

        // Reset during scan drops the event.
        do_reset();
        valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
        step();
        valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst ready", int'(o_EventReady), 0);
        chk("midrst we", int'(o_WriteEnable), 0);
        chk("midrst keyon", int'(o_VoiceKeyOn), 0);
        step();
        step();
        rst = 1'b0;
        chk("midrst ready held", int'(o_EventReady), 0);
        step();
        chk("midrst ready after", int'(o_EventReady), 1);
        begin
            int saw = 0;
            for (int c = 0; c < 15; c++) begin
                step();
                if (o_WriteEnable) saw++;
            end
            chk("midrst no strobe", saw, 0);
            chk("midrst count", int'(o_ActiveCount), 0);
        end

        // Randomized events and ticks against the reference model.
        do_reset();
        for (int ev = 0; ev < 80; ev++) begin
            int k;
            int r_on;
            int r_note;
            int r_vel;
            k = $urandom_range(0, 6);
            for (int c = 0; c < k; c++) begin
                tick = ($urandom_range(0, 1) == 1);
                step();
                if (tick) m_tick();
                tick = 1'b0;
            end
            r_on = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r_note = 60 + $urandom_range(0, 9);
            r_vel = $urandom_range(1, 127);
            run_event(r_on[0], r_note, r_vel, 1'b1);
            if (acc_tick) m_tick();
            m_event(r_on, r_note, r_vel);
            check_event($sformatf("rnd%0d", ev), m_keyon(), m_count());
            if (busy_tick) m_tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice allocator and sequencer in front of the FM voice bank.
- Accepts note-on/note-off events over a valid/ready handshake and picks a voice: retrigger, free, oldest releasing, or steal oldest active.
- Issues one-cycle register writes (KeyOn, note, velocity) into the per-voice register file.
- Tracks per-voice state and age so release tails finish before a voice is reused.

Parameters:
NUM_VOICES, 8, number of voices managed; power of two, >= 2.
VIDX_WIDTH, $clog2(NUM_VOICES), voice index width (derived, not overridden).
AGE_WIDTH, 8, per-voice age counter width; saturating.
RELEASE_TICKS, 32, sample ticks a voice stays RELEASING before becoming FREE; 1..2^AGE_WIDTH-1.

Ports:
i_Clock  in  1  system clock; single clock domain.
i_Reset  in  1  asynchronous, active-high reset.
i_SampleTick  in  1  one-cycle pulse per output sample.
i_EventValid  in  1  event present.
o_EventReady  out  1  allocator can accept an event.
i_EventNoteOn  in  1  1 = note-on, 0 = note-off.
i_EventNote  in  7  MIDI note number.
i_EventVelocity  in  7  velocity; ignored for note-off.
o_WriteEnable  out  1  one-cycle voice register write strobe.
o_WriteVoice  out  VIDX_WIDTH  target voice.
o_WriteKeyOn  out  1  KeyOn value to write.
o_WriteNote  out  7  note to write.
o_WriteVelocity  out  7  velocity to write.
o_VoiceKeyOn  out  NUM_VOICES  bit v = 1 when voice v is ACTIVE.
o_ActiveCount  out  $clog2(NUM_VOICES+1)  number of ACTIVE voices.

Behaviour:
- Voice state per voice: FREE, ACTIVE, RELEASING; stored note (7 bits); age (AGE_WIDTH bits).
- Reset (async): all voices FREE, notes 0, ages 0, FSM IDLE, all outputs 0, including o_EventReady. o_EventReady rises on the first clock edge after reset deasserts.
- FSM states: IDLE, SCAN, KILL, WRITE.
- IDLE: o_EventReady = 1 (registered). On valid && ready, latch the event and go to SCAN with scan index 0.
- SCAN: examine one voice per cycle, index 0..NUM_VOICES-1, keeping the best candidate. After the last index, go to KILL or WRITE.
- Note-on priority (ties go to the lowest index):
  1. Voice with matching note, ACTIVE or RELEASING (retrigger).
  2. Any FREE voice.
  3. RELEASING voice with the largest age.
  4. ACTIVE voice with the largest age (steal).
- Note-on: if the chosen voice is ACTIVE, enter KILL (write KeyOn=0, note=old note, velocity=0), then WRITE. Otherwise go straight to WRITE.
- WRITE: write KeyOn=1, latched note and velocity. Voice becomes ACTIVE, age = 0. Return to IDLE.
- Note-off: target is the lowest-index ACTIVE voice with a matching note. WRITE issues KeyOn=0, note, velocity=0; voice becomes RELEASING, age = 0.
- Note-off with no match: no write strobe. FSM goes SCAN -> IDLE; the event is still consumed.
- Latency from the accept edge (cycle 0): scan in cycles 1..NUM_VOICES, KILL (if any) at NUM_VOICES+1, write strobe at NUM_VOICES+1 (no kill) or NUM_VOICES+2 (kill). o_EventReady = 1 the cycle after the final strobe.
- Write outputs are registered. o_WriteEnable is high exactly one cycle per write, and the other write outputs are valid in that cycle. Otherwise o_WriteEnable = 0 and the write fields hold their last value.
- Tick processing while FSM is IDLE: on i_SampleTick every non-FREE voice age increments, saturating at all-ones. A RELEASING voice whose incremented age reaches RELEASE_TICKS becomes FREE in the same edge.
- Tick processing while FSM is not IDLE: ticks set a single pending flag; multiple ticks collapse to one. The pending tick is applied on the cycle the FSM re-enters IDLE.
- If the cycle re-entering IDLE also carries a new tick, only one increment is applied.
- A tick coinciding with an event accept in IDLE is applied before the scan starts; the scan sees post-tick state.
- o_VoiceKeyOn and o_ActiveCount are registered from the state vector and update in the cycle after a state change.
- Reset mid-operation: the event is dropped, no further write strobe is issued, and all state returns to reset values.

Test Plan:
- Reset, then note-on (note 60, vel 100) -> strobe at cycle 9 with voice 0, KeyOn=1, 60, 100; o_VoiceKeyOn = 8'h01; o_ActiveCount = 1.
- Eight note-ons (notes 60..67), then note 70 with 3 ticks between events -> 70 steals voice 0 (oldest): KILL write (voice 0, KeyOn=0, 60) at cycle 9, KeyOn=1 write (note 70) at cycle 10.
- Note-on 60, then note-off 60 -> voice 0 RELEASING; after 31 ticks still RELEASING; on the 32nd tick it becomes FREE. A new note-on before that goes to voice 1, after it to voice 0.
- Note-off 72 with no voice holding 72 -> no o_WriteEnable; o_EventReady = 1 again at cycle 9.
- Note-on 60 twice -> second event retriggers voice 0 via KILL + WRITE; voice 1 stays FREE.
- Assert i_Reset during SCAN of a note-on -> no write strobe; all outputs 0; o_EventReady = 1 on the first edge after release.
